seq3: RTL

SEQ3 -- requirements
Module: seq3

---
 rtl/seq3_pkg.sv | 27 ++
 rtl/seq3_stack.sv | 46 ++++
 rtl/seq3.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seq3_pkg.sv
// Shared opcode and FSM state encodings for the seq3 instruction sequencer.
package seq3_pkg;

   typedef enum logic [3:0] {
      OP_NO = 4'h0,
      OP_CI = 4'h1,
      OP_CR = 4'h2,
      OP_JI = 4'h3,
      OP_JR = 4'h4,
      OP_JZ = 4'h5,
      OP_WN = 4'h6,
      OP_WZ = 4'h7,
      OP_LC = 4'h8,
      OP_DJ = 4'h9,
      OP_CL = 4'hA,
      OP_RT = 4'hB
   } opcode_t;

   typedef enum logic [2:0] {
      ST_RESET   = 3'd0,
      ST_READY   = 3'd1,
      ST_WAIT_NZ = 3'd2,
      ST_WAIT_Z  = 3'd3,
      ST_ERROR   = 3'd4
   } state_t;

endpackage

// File: rtl/seq3_stack.sv
// Return-address LIFO for CL/RT; push/pop take effect on the clock edge, top is combinational.
// Push when full / pop when empty are ignored here; the sequencer traps them as errors.
module seq3_stack
   import seq3_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_dat,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] top
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] count;
   logic [W-1:0]  mem [DEPTH];

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else if (push && !full) begin
         for (int k = 0; k < DEPTH; k++)
            if (count == CW'(k)) mem[k] <= push_dat;
         count <= count + CW'(1);
      end else if (pop && !empty) begin
         count <= count - CW'(1);
      end
   end

   always_comb begin
      top = '0;
      for (int k = 0; k < DEPTH; k++)
         if (count == CW'(k + 1)) top = mem[k];
   end

endmodule

// File: rtl/seq3.sv
// Micro-sequencer: one instruction per accepted cycle, outputs registered one cycle later.
// Waits stall on ireg conditions; CL/RT call stack exists only when SEQ3_CALL_EN is defined.
module seq3
   import seq3_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int NUM_IREG    = 4,
   parameter int NUM_OREG    = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [23:0]           inst,
   input  logic                  inst_en,
   input  logic [8*NUM_IREG-1:0] ireg,
   output logic [ADDR_W-1:0]     next,
   output logic [11:0]           oreg,
   output logic [NUM_OREG-1:0]   oreg_wen,
   output logic                  error
);

   state_t              state;
   opcode_t             op;
   logic [3:0]          dst, src, sel_src, wait_src;
   logic [11:0]         imm;
   logic [7:0]          sel, counter, cnt_dec;
   logic [19:0]         sel_ext;
   logic [NUM_OREG-1:0] dst_oh;
   logic [ADDR_W-1:0]   next_inc;
   logic                fields_ok, op_ok, legal;

   assign op       = opcode_t'(inst[23:20]);
   assign dst      = inst[19:16];
   assign src      = inst[15:12];
   assign imm      = inst[11:0];
   assign next_inc = next + ADDR_W'(1);
   assign cnt_dec  = counter - 8'd1;
   assign sel_ext  = {12'd0, sel};

   // While stalled, the condition tracks the register latched at the wait instruction.
   assign sel_src = (state == ST_WAIT_NZ || state == ST_WAIT_Z) ? wait_src : src;

   always_comb begin
      sel = '0;
      for (int k = 0; k < NUM_IREG; k++)
         if (sel_src == 4'(k)) sel = ireg[8*k +: 8];
   end

   always_comb begin
      dst_oh = '0;
      for (int k = 0; k < NUM_OREG; k++)
         dst_oh[k] = (dst == 4'(k));
   end

   assign fields_ok = (32'(src) < NUM_IREG) && (32'(dst) < NUM_OREG);

`ifdef SEQ3_CALL_EN
   logic              stk_push, stk_pop, stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_top;

   assign stk_push = (state == ST_READY) && inst_en && legal && (op == OP_CL);
   assign stk_pop  = (state == ST_READY) && inst_en && legal && (op == OP_RT);

   seq3_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (ADDR_W)
   ) u_stack (
      .clock    (clock),
      .reset    (reset),
      .push     (stk_push),
      .pop      (stk_pop),
      .push_dat (next_inc),
      .full     (stk_full),
      .empty    (stk_empty),
      .top      (stk_top)
   );
`endif

   always_comb begin
      op_ok = 1'b0;
      case (op)
         OP_NO, OP_CI, OP_CR, OP_JI, OP_JR,
         OP_JZ, OP_WN, OP_WZ, OP_LC, OP_DJ: op_ok = 1'b1;
`ifdef SEQ3_CALL_EN
         OP_CL: op_ok = !stk_full;
         OP_RT: op_ok = !stk_empty;
`endif
         default: op_ok = 1'b0;
      endcase
   end

   assign legal = fields_ok && op_ok;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_RESET;
         next     <= '0;
         oreg     <= '0;
         oreg_wen <= '0;
         counter  <= '0;
         wait_src <= '0;
         error    <= 1'b0;
      end else begin
         oreg     <= '0;
         oreg_wen <= '0;
         case (state)
            ST_RESET: state <= ST_READY;
            ST_READY: begin
               if (inst_en) begin
                  if (!legal) begin
                     state <= ST_ERROR;
                     next  <= '0;
                     error <= 1'b1;
                  end else begin
                     case (op)
                        OP_NO: next <= next_inc;
                        OP_CI: begin
                           oreg     <= imm;
                           oreg_wen <= dst_oh;
                           next     <= next_inc;
                        end
                        OP_CR: begin
                           oreg     <= {imm[11:8], sel};
                           oreg_wen <= dst_oh;
                           next     <= next_inc;
                        end
                        OP_JI: next <= imm[ADDR_W-1:0];
                        OP_JR: next <= sel_ext[ADDR_W-1:0];
                        OP_JZ: next <= (sel == 8'd0) ? imm[ADDR_W-1:0] : next_inc;
                        OP_WN: begin
                           wait_src <= src;
                           if (sel != 8'd0) next <= next_inc;
                           else             state <= ST_WAIT_NZ;
                        end
                        OP_WZ: begin
                           wait_src <= src;
                           if (sel == 8'd0) next <= next_inc;
                           else             state <= ST_WAIT_Z;
                        end
                        OP_LC: begin
                           counter <= imm[7:0];
                           next    <= next_inc;
                        end
                        OP_DJ: begin
                           counter <= cnt_dec;
                           next    <= (cnt_dec != 8'd0) ? imm[ADDR_W-1:0] : next_inc;
                        end
`ifdef SEQ3_CALL_EN
                        OP_CL: next <= imm[ADDR_W-1:0];
                        OP_RT: next <= stk_top;
`endif
                        default: begin
                           state <= ST_ERROR;
                           next  <= '0;
                           error <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            ST_WAIT_NZ: begin
               if (inst_en && sel != 8'd0) begin
                  state <= ST_READY;
                  next  <= next_inc;
               end
            end
            ST_WAIT_Z: begin
               if (inst_en && sel == 8'd0) begin
                  state <= ST_READY;
                  next  <= next_inc;
               end
            end
            ST_ERROR: begin
               next  <= '0;
               error <= 1'b1;
            end
            default: begin
               state <= ST_ERROR;
               next  <= '0;
               error <= 1'b1;
            end
         endcase
      end
   end

endmodule
